// File: rtl/irq_pending_encoder.sv
// Edge-detecting pending register feeding a priority encoder; bit 7 wins.
// Latency: req edge -> pending +1, code/valid +2; code holds until ack, with one idle gap between offers.
module irq_pending_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic         overflow
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] req_q;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] sel;
  logic [W-1:0] code_nxt;

  assign rise = req & ~req_q;
  assign sel  = pending & ~mask;

  always_comb begin
    clr = '0;
    if (state == OFFER && ack) clr[code] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    case (state)
      IDLE: begin
        if (|sel) begin
          // Ascending scan: the last hit is the highest-priority bit.
          for (int i = 0; i < N; i++) begin
            if (sel[i]) code_nxt = W'(i);
          end
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_q    <= '0;
      pending  <= '0;
      code     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_q    <= req;
      // A rise in the same cycle as its clear keeps the bit pending.
      pending  <= (pending & ~clr) | rise;
      code     <= code_nxt;
      valid    <= (state_nxt == OFFER);
      overflow <= |(rise & pending & ~clr);
    end
  end

endmodule

// File: tb/tb_irq_pending_encoder.sv
// Directed bench for irq_pending_encoder with a cycle model and literal spot checks.
module tb_irq_pending_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  irq_pending_encoder #(.N(8), .W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack),
    .code(code), .valid(valid), .pending(pending), .overflow(overflow)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference: what the outputs must be, from the request/ack rules.
  logic [7:0] m_req_q, m_pend;
  logic [2:0] m_code;
  logic       m_valid, m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req_q = 0; m_pend = 0; m_code = 0; m_valid = 0; m_ovf = 0;
    end else begin
      logic [7:0] rs, cl, sl, np;
      rs = req & ~m_req_q;
      cl = (m_valid && ack) ? (8'd1 << m_code) : 8'd0;
      np = (m_pend & ~cl) | rs;
      m_ovf = |(rs & m_pend & ~cl);
      if (!m_valid) begin
        sl = m_pend & ~mask;
        for (int b = 7; b >= 0; b--) begin
          if (sl[b]) begin
            m_code = 3'(b);
            m_valid = 1;
            break;
          end
        end
      end else if (ack) begin
        m_valid = 0;
      end
      m_pend = np;
      m_req_q = req;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("model_valid", 32'(valid), 32'(m_valid));
      check("model_code", 32'(code), 32'(m_code));
      check("model_pending", 32'(pending), 32'(m_pend));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; req = 0; mask = 0; ack = 0;
    tick(); tick();
    check("reset_valid", 32'(valid), 0);
    check("reset_pending", 32'(pending), 0);
    check("reset_code", 32'(code), 0);
    rst_n = 1;
    cmp_en = 1;
    tick();

    // 1: single request
    req = 8'h04; tick();
    check("t1_pending", 32'(pending), 32'h04);
    check("t1_valid_early", 32'(valid), 0);
    req = 0; tick();
    check("t1_valid", 32'(valid), 1);
    check("t1_code", 32'(code), 2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t1_hold", 32'(code), 2);
    end
    ack = 1; tick();
    check("t1_ack_valid", 32'(valid), 0);
    check("t1_ack_pending", 32'(pending), 0);
    ack = 0; tick();

    // 2: priority order 7, 4, 1
    req = 8'h92; tick();
    check("t2_pending", 32'(pending), 32'h92);
    req = 0; tick();
    check("t2_code7", 32'(code), 7);
    ack = 1; tick();
    check("t2_gap1", 32'(valid), 0);
    ack = 0; tick();
    check("t2_code4", 32'(code), 4);
    check("t2_valid4", 32'(valid), 1);
    ack = 1; tick();
    check("t2_gap2", 32'(valid), 0);
    ack = 0; tick();
    check("t2_code1", 32'(code), 1);
    ack = 1; tick();
    check("t2_final_pending", 32'(pending), 0);
    ack = 0; tick();
    check("t2_idle", 32'(valid), 0);

    // 3: hold during offer
    req = 8'h02; tick();
    req = 0; tick();
    check("t3_code1", 32'(code), 1);
    req = 8'h80; tick();
    check("t3_overlap_pending", 32'(pending), 32'h82);
    check("t3_hold_code", 32'(code), 1);
    req = 0; ack = 1; tick();
    check("t3_ack_valid", 32'(valid), 0);
    ack = 0; tick();
    check("t3_code7", 32'(code), 7);
    ack = 1; tick();
    ack = 0; tick();

    // 4: mask
    mask = 8'h80; req = 8'h81; tick();
    req = 0; tick();
    check("t4_code0", 32'(code), 0);
    check("t4_valid", 32'(valid), 1);
    ack = 1; tick();
    ack = 0; tick();
    check("t4_masked_valid", 32'(valid), 0);
    check("t4_masked_pending", 32'(pending), 32'h80);
    tick();
    check("t4_still_idle", 32'(valid), 0);
    mask = 0; tick();
    check("t4_code7", 32'(code), 7);
    check("t4_valid7", 32'(valid), 1);
    ack = 1; tick();
    ack = 0; tick();

    // 5: overflow and set-wins
    req = 8'h08; tick();
    tick();
    check("t5_code3", 32'(code), 3);
    req = 0; tick();
    req = 8'h08; tick();
    check("t5_overflow", 32'(overflow), 1);
    check("t5_pending3", 32'(pending), 32'h08);
    tick();
    check("t5_overflow_pulse", 32'(overflow), 0);
    req = 0; tick();
    req = 8'h08; ack = 1; tick();
    check("t5_setwins_pending", 32'(pending), 32'h08);
    check("t5_setwins_ovf", 32'(overflow), 0);
    check("t5_gap", 32'(valid), 0);
    ack = 0; tick();
    check("t5_reoffer", 32'(code), 3);
    check("t5_reoffer_valid", 32'(valid), 1);
    req = 0; ack = 1; tick();
    ack = 0; tick();

    // 6: asynchronous reset mid-offer
    req = 8'h30; tick();
    req = 0; tick();
    check("t6_pending", 32'(pending), 32'h30);
    check("t6_valid", 32'(valid), 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("t6_rst_valid", 32'(valid), 0);
    check("t6_rst_code", 32'(code), 0);
    check("t6_rst_pending", 32'(pending), 0);
    check("t6_rst_overflow", 32'(overflow), 0);
    tick();
    req = 8'h01; rst_n = 1;
    tick();
    check("t6_post_pending", 32'(pending), 32'h01);
    check("t6_post_valid_early", 32'(valid), 0);
    tick();
    check("t6_post_valid", 32'(valid), 1);
    check("t6_post_code", 32'(code), 0);
    ack = 1; tick();
    ack = 0; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_pending_encoder.md
Name: irq_pending_encoder

Overview:
- Sequential front end for the 8-to-3 priority encoder.
- Edge-detects 8 request lines and latches each request into a pending register.
- Offers the highest-priority unmasked pending request as a 3-bit code with a valid/ack handshake. Bit 7 has the highest priority; bit 0 the lowest.
- The acknowledged bit is cleared from the pending register; lower-priority requests are then offered in turn.

Parameters:
- N, 8: number of request lines. Fixed at 8 for this revision.
- W, 3: code width. Must equal clog2(N).

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, N: request lines, synchronous to clk. A 0->1 transition marks a new event.
- mask, input, N: 1 = bit excluded from selection. The bit still latches into pending.
- ack, input, 1: consumer accepts the current code. Only meaningful while valid = 1.
- code, output, W: index of the offered request.
- valid, output, 1: code is valid.
- pending, output, N: current pending register.
- overflow, output, 1: one-cycle pulse when a rising edge hits a bit that is already pending.

Behaviour:
- Reset (asynchronous, rst_n = 0): req_q, pending, code, valid and overflow all go to 0; state goes to IDLE.
  - Because req_q resets to 0, a req bit held high through reset registers as a rise at the first edge after reset.
- Edge detect: rise = req & ~req_q, with req_q <= req every cycle.
- Clear vector: clr = onehot(code) when (state == OFFER && ack), otherwise 0.
- Pending update: pending <= (pending & ~clr) | rise.
  - If a bit rises and is cleared in the same cycle, the set wins and the bit stays pending.
- Overflow: overflow <= |(rise & pending & ~clr). It is a one-cycle pulse, not sticky.
- State IDLE (valid = 0):
  - sel = pending & ~mask, using the registered pending.
  - If sel != 0: code <= index of the highest set bit of sel; valid <= 1; go to OFFER.
  - Otherwise remain in IDLE; code holds its last value.
- State OFFER (valid = 1):
  - code is held stable until ack, even if a higher-priority request arrives or the offered bit becomes masked. There is no withdrawal.
  - On ack: valid <= 0, pending[code] is cleared per clr, go to IDLE.
- Handshake gap: there is one idle cycle (valid = 0) between consecutive offers.
- ack while valid = 0 is ignored and has no effect.
- Latency:
  - req sampled high at edge t -> pending bit set after edge t -> valid/code asserted after edge t+1.
  - ack sampled at edge a -> valid low after edge a -> next offer, if any, valid after edge a+1.
- Masked pending bits stay pending indefinitely; they are offered once unmasked.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
1. Single request:
   - Stimulus: reset, then req = 8'b00000100 for one cycle.
   - Required response: pending = 8'h04 after 1 edge; valid = 1, code = 3'd2 after 2 edges. Hold ack = 0 for 3 cycles: code stays 2. Pulse ack: valid = 0 and pending = 0 the next cycle.
2. Priority order:
   - Stimulus: req = 8'b10010010 in one cycle.
   - Required response: offers code 7, then 4, then 1, each after ack, with exactly one valid = 0 cycle between offers. Final pending = 0.
3. Hold during offer:
   - Stimulus: code 1 is offered; req[7] rises while valid = 1.
   - Required response: code stays 1 until ack. The next offer is code 7. pending = 8'h82 during the overlap.
4. Mask:
   - Stimulus: pending = 8'h81, mask = 8'h80.
   - Required response: code 0 is offered. After ack, valid stays 0 and pending = 8'h80. Clearing mask -> code 7 offered one cycle later.
5. Overflow and set-wins:
   - Stimulus: bit 3 pending and offered; req[3] falls and rises again before ack.
   - Required response: overflow pulses for exactly 1 cycle, and pending[3] stays 1.
   - Stimulus: ack coincides with a new rise on bit 3.
   - Required response: pending[3] stays 1, and code 3 is re-offered after the gap cycle.
6. Reset mid-offer:
   - Stimulus: rst_n driven low between clock edges while valid = 1 and pending = 8'h30.
   - Required response: valid, code, pending and overflow read 0 immediately, with no clock edge.
   - Stimulus: release rst_n with req = 8'h01 held high.
   - Required response: code 0 is offered 2 edges later.
